// File: rtl/updown_counter_param.sv
// Parametrised loadable up/down counter with programmable step, runtime limits,
// wrap/saturate mode and registered overflow/underflow event pulses.
module updown_counter_param #(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              load,
  input  logic [WIDTH-1:0]  din,
  input  logic              en,
  input  logic              up_down,
  input  logic [STEP_W-1:0] step,
  input  logic [WIDTH-1:0]  lo_lim,
  input  logic [WIDTH-1:0]  hi_lim,
  input  logic              sat_mode,
  output logic [WIDTH-1:0]  count,
  output logic              ovf,
  output logic              unf,
  output logic              at_hi,
  output logic              at_lo,
  output logic              cfg_err
);

  logic [WIDTH:0] step_ext;
  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;
  logic           step_nz;
  logic           ovf_cond;
  logic           unf_cond;
  logic           cnt_act;

  assign step_ext = {{(WIDTH+1-STEP_W){1'b0}}, step};
  assign sum      = {1'b0, count} + step_ext;
  assign diff     = {1'b0, count} - step_ext;
  assign step_nz  = (step != '0);

  assign ovf_cond = (sum > {1'b0, hi_lim});
  // diff[WIDTH] set means count - step went negative, always below lo_lim
  assign unf_cond = diff[WIDTH] | (diff[WIDTH-1:0] < lo_lim);

  assign cfg_err = (lo_lim > hi_lim);
  assign at_hi   = (count == hi_lim);
  assign at_lo   = (count == lo_lim);
  assign cnt_act = en & ~cfg_err & step_nz;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else begin
      ovf <= 1'b0;
      unf <= 1'b0;
      if (clr) begin
        count <= lo_lim;
      end else if (load) begin
        count <= din;
      end else if (cnt_act) begin
        if (!up_down) begin
          if (ovf_cond) begin
            count <= sat_mode ? hi_lim : lo_lim;
            ovf   <= 1'b1;
          end else begin
            count <= sum[WIDTH-1:0];
          end
        end else begin
          if (unf_cond) begin
            count <= sat_mode ? lo_lim : hi_lim;
            unf   <= 1'b1;
          end else begin
            count <= diff[WIDTH-1:0];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_updown_counter_param.sv
// Directed table-driven bench for updown_counter_param (WIDTH=8, STEP_W=4).
module tb_updown_counter_param;

  logic       clk;
  logic       rst_n;
  logic       clr;
  logic       load;
  logic [7:0] din;
  logic       en;
  logic       up_down;
  logic [3:0] step;
  logic [7:0] lo_lim;
  logic [7:0] hi_lim;
  logic       sat_mode;
  logic [7:0] count;
  logic       ovf;
  logic       unf;
  logic       at_hi;
  logic       at_lo;
  logic       cfg_err;

  int n_checks = 0;
  int n_fail   = 0;

  updown_counter_param #(.WIDTH(8), .STEP_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .din(din), .en(en),
    .up_down(up_down), .step(step), .lo_lim(lo_lim), .hi_lim(hi_lim),
    .sat_mode(sat_mode), .count(count), .ovf(ovf), .unf(unf),
    .at_hi(at_hi), .at_lo(at_lo), .cfg_err(cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       clr;
    logic       load;
    logic [7:0] din;
    logic       en;
    logic       up_down;
    logic [3:0] step;
    logic [7:0] lo;
    logic [7:0] hi;
    logic       sat;
    logic [7:0] e_count;
    logic       e_ovf;
    logic       e_unf;
    logic       e_hi;
    logic       e_lo;
    logic       e_err;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic c, input logic l, input logic [7:0] d,
                     input logic e, input logic ud, input logic [3:0] s,
                     input logic [7:0] lo, input logic [7:0] hi, input logic sat,
                     input logic [7:0] ec, input logic eo, input logic eu,
                     input logic eh, input logic el, input logic ee);
    vec_t v;
    v.clr = c; v.load = l; v.din = d; v.en = e; v.up_down = ud; v.step = s;
    v.lo = lo; v.hi = hi; v.sat = sat;
    v.e_count = ec; v.e_ovf = eo; v.e_unf = eu; v.e_hi = eh; v.e_lo = el; v.e_err = ee;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic [7:0] ec, input logic eo,
                           input logic eu, input logic eh, input logic el, input logic ee);
    check({tag, ".count"},   {24'd0, count}, {24'd0, ec});
    check({tag, ".ovf"},     {31'd0, ovf},     {31'd0, eo});
    check({tag, ".unf"},     {31'd0, unf},     {31'd0, eu});
    check({tag, ".at_hi"},   {31'd0, at_hi},   {31'd0, eh});
    check({tag, ".at_lo"},   {31'd0, at_lo},   {31'd0, el});
    check({tag, ".cfg_err"}, {31'd0, cfg_err}, {31'd0, ee});
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; load = 1'b0; din = 8'h00; en = 1'b0; up_down = 1'b0;
    step = 4'd1; lo_lim = 8'h00; hi_lim = 8'hFF; sat_mode = 1'b0;

    // wrap up: lo=10 hi=20 step=3
    add(0,1,8'd18,0,0,4'd3,8'd10,8'd20,0,  8'd18,0,0,0,0,0);
    add(0,0,8'd0 ,1,0,4'd3,8'd10,8'd20,0,  8'd10,1,0,0,1,0);
    add(0,0,8'd0 ,1,0,4'd3,8'd10,8'd20,0,  8'd13,0,0,0,0,0);
    add(0,0,8'd0 ,1,0,4'd3,8'd10,8'd20,0,  8'd16,0,0,0,0,0);
    // saturate down: lo=5 hi=200 step=4
    add(0,1,8'd7 ,0,1,4'd4,8'd5,8'd200,1,  8'd7,0,0,0,0,0);
    add(0,0,8'd0 ,1,1,4'd4,8'd5,8'd200,1,  8'd5,0,1,0,1,0);
    add(0,0,8'd0 ,1,1,4'd4,8'd5,8'd200,1,  8'd5,0,1,0,1,0);
    add(0,0,8'd0 ,0,1,4'd4,8'd5,8'd200,1,  8'd5,0,0,0,1,0);
    // saturate up
    add(0,1,8'd198,0,0,4'd4,8'd5,8'd200,1, 8'd198,0,0,0,0,0);
    add(0,0,8'd0 ,1,0,4'd4,8'd5,8'd200,1,  8'd200,1,0,1,0,0);
    add(0,0,8'd0 ,1,0,4'd4,8'd5,8'd200,1,  8'd200,1,0,1,0,0);
    // priority and zero step
    add(1,1,8'h55,1,0,4'd1,8'h10,8'hF0,0,  8'h10,0,0,0,1,0);
    add(0,1,8'h55,1,0,4'd1,8'h10,8'hF0,0,  8'h55,0,0,0,0,0);
    add(0,0,8'h00,1,0,4'd0,8'h10,8'hF0,0,  8'h55,0,0,0,0,0);
    add(0,0,8'h00,1,1,4'd0,8'h10,8'hF0,0,  8'h55,0,0,0,0,0);
    // full range
    add(0,1,8'hFF,0,0,4'd1,8'h00,8'hFF,0,  8'hFF,0,0,1,0,0);
    add(0,0,8'h00,1,0,4'd1,8'h00,8'hFF,0,  8'h00,1,0,0,1,0);
    add(0,0,8'h00,1,1,4'd1,8'h00,8'hFF,0,  8'hFF,0,1,1,0,0);
    add(0,0,8'h00,1,1,4'd1,8'h00,8'hFF,0,  8'hFE,0,0,0,0,0);
    add(0,1,8'hF5,0,0,4'd15,8'h00,8'hFF,1, 8'hF5,0,0,0,0,0);
    add(0,0,8'h00,1,0,4'd15,8'h00,8'hFF,1, 8'hFF,1,0,1,0,0);
    // outside limits after load
    add(0,1,8'd50,0,0,4'd1,8'd10,8'd20,0,  8'd50,0,0,0,0,0);
    add(0,0,8'd0 ,1,0,4'd1,8'd10,8'd20,0,  8'd10,1,0,0,1,0);
    add(0,1,8'd2 ,0,1,4'd1,8'd10,8'd20,0,  8'd2,0,0,0,0,0);
    add(0,0,8'd0 ,1,1,4'd1,8'd10,8'd20,0,  8'd20,0,1,1,0,0);
    add(0,1,8'd2 ,0,0,4'd1,8'd10,8'd20,0,  8'd2,0,0,0,0,0);
    add(0,0,8'd0 ,1,0,4'd1,8'd10,8'd20,0,  8'd3,0,0,0,0,0);
    // config error: lo=30 hi=20
    add(0,0,8'd0 ,1,0,4'd1,8'd30,8'd20,0,  8'd3,0,0,0,0,1);
    add(0,0,8'd0 ,1,1,4'd1,8'd30,8'd20,0,  8'd3,0,0,0,0,1);
    add(0,1,8'h40,1,0,4'd1,8'd30,8'd20,0,  8'h40,0,0,0,0,1);
    add(1,0,8'h00,1,0,4'd1,8'd30,8'd20,0,  8'd30,0,0,0,1,1);

    // reset and asynchronous mid-count reset
    repeat (2) @(posedge clk);
    #1 check_all("rst_hold", 8'h00, 0, 0, 0, 1, 0);
    @(negedge clk);
    rst_n = 1'b1;
    en = 1'b1;
    repeat (8'h37) @(posedge clk);
    #1 check("cnt_to_37", {24'd0, count}, 32'h37);
    #2 rst_n = 1'b0;
    #1 check_all("async_rst", 8'h00, 0, 0, 0, 1, 0);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1 check("resume_after_rst", {24'd0, count}, 32'h01);
    en = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      clr = vecs[i].clr; load = vecs[i].load; din = vecs[i].din; en = vecs[i].en;
      up_down = vecs[i].up_down; step = vecs[i].step; lo_lim = vecs[i].lo;
      hi_lim = vecs[i].hi; sat_mode = vecs[i].sat;
      @(posedge clk);
      #1 check_all($sformatf("vec%0d", i), vecs[i].e_count, vecs[i].e_ovf,
                   vecs[i].e_unf, vecs[i].e_hi, vecs[i].e_lo, vecs[i].e_err);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
